// File: rtl/line_pkg.sv
// Shared types and width helpers for the line rasterizer.
package line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

  // Signed error-term width: two bits of headroom cover 2*err without overflow.
  function automatic int unsigned err_w(input int unsigned xw, input int unsigned yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Command and pixel handshake bundle between a line producer and the rasterizer.
interface line_rasterizer_if #(
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned Y_WIDTH     = 9,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned PAT_WIDTH   = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [X_WIDTH-1:0]     cmd_x0;
  logic [X_WIDTH-1:0]     cmd_x1;
  logic [Y_WIDTH-1:0]     cmd_y0;
  logic [Y_WIDTH-1:0]     cmd_y1;
  logic [COLOR_WIDTH-1:0] cmd_color;
  logic [PAT_WIDTH-1:0]   cmd_pattern;
  logic                   abort;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [X_WIDTH-1:0]     pix_x;
  logic [Y_WIDTH-1:0]     pix_y;
  logic [COLOR_WIDTH-1:0] pix_color;
  logic                   pix_last;
  logic                   busy;
  logic                   done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_pattern, abort, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_pattern, abort, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last, busy, done
  );
endinterface

// File: rtl/line_step.sv
// One Bresenham step: next error term and point from the current ones.
module line_step
  import line_pkg::*;
#(
  parameter int unsigned X_WIDTH = 10,
  parameter int unsigned Y_WIDTH = 9,
  parameter int unsigned ERR_W   = err_w(X_WIDTH, Y_WIDTH)
) (
  input  logic signed [ERR_W-1:0] err_i,
  input  logic signed [ERR_W-1:0] dx_i,
  input  logic signed [ERR_W-1:0] dy_i,
  input  logic [X_WIDTH-1:0]      x_i,
  input  logic [Y_WIDTH-1:0]      y_i,
  input  logic                    sx_neg_i,
  input  logic                    sy_neg_i,
  output logic signed [ERR_W-1:0] err_c_o,
  output logic [X_WIDTH-1:0]      x_c_o,
  output logic [Y_WIDTH-1:0]      y_c_o
);

  logic signed [ERR_W-1:0] e2;
  logic signed [ERR_W-1:0] err_acc;

  // Both tests use the old err/e2; either, both or neither axis may move.
  always_comb begin
    e2      = err_i <<< 1;
    err_acc = err_i;
    x_c_o   = x_i;
    y_c_o   = y_i;
    if (e2 >= dy_i) begin
      err_acc = err_acc + dy_i;
      x_c_o   = sx_neg_i ? (x_i - X_WIDTH'(1)) : (x_i + X_WIDTH'(1));
    end
    if (e2 <= dx_i) begin
      err_acc = err_acc + dx_i;
      y_c_o   = sy_neg_i ? (y_i - Y_WIDTH'(1)) : (y_i + Y_WIDTH'(1));
    end
    err_c_o = err_acc;
  end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts a line command and streams clipped, dashed pixels.
module line_rasterizer
  import line_pkg::*;
#(
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned Y_WIDTH     = 9,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned PAT_WIDTH   = 16,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 400
) (
  input  logic               clk,
  input  logic               reset,
  line_rasterizer_if.slave   bus
);

  localparam int unsigned ERR_W = err_w(X_WIDTH, Y_WIDTH);
  localparam int unsigned IDX_W = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
  localparam int unsigned CMP_W = ERR_W + 32;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [X_WIDTH-1:0]      x_q, x_d, x1_q, x1_d;
  logic [Y_WIDTH-1:0]      y_q, y_d, y1_q, y1_d;
  logic [COLOR_WIDTH-1:0]  color_q, color_d;
  logic [PAT_WIDTH-1:0]    pat_q, pat_d;
  logic signed [ERR_W-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    pix_last_q, pix_last_d;
  logic                    done_q, done_d;

  logic signed [ERR_W-1:0] step_err;
  logic [X_WIDTH-1:0]      step_x;
  logic [Y_WIDTH-1:0]      step_y;
  logic signed [ERR_W-1:0] ddx, ddy;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    at_end;
  logic                    advance;

  function automatic logic is_visible(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y,
                                      input logic pat_bit);
    return (CMP_W'(x) < CMP_W'(H_RES)) && (CMP_W'(y) < CMP_W'(V_RES)) && pat_bit;
  endfunction

  line_step #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .ERR_W   (ERR_W)
  ) u_step (
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .err_c_o  (step_err),
    .x_c_o    (step_x),
    .y_c_o    (step_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      pat_q       <= '0;
      err_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      idx_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      pat_q       <= pat_d;
      err_q       <= err_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      idx_q       <= idx_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
    end
  end

  // Pixel outputs are registered one step ahead so a stalled pixel simply holds.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    pat_d       = pat_q;
    err_d       = err_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    idx_d       = idx_q;
    pix_valid_d = 1'b0;
    pix_last_d  = 1'b0;
    done_d      = 1'b0;
    ddx         = $signed(ERR_W'(x1_q)) - $signed(ERR_W'(x_q));
    ddy         = $signed(ERR_W'(y1_q)) - $signed(ERR_W'(y_q));
    idx_nxt     = (idx_q == IDX_MAX) ? '0 : (idx_q + IDX_W'(1));
    at_end      = (x_q == x1_q) && (y_q == y1_q);
    advance     = !pix_valid_q || bus.pix_ready;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && !bus.abort) begin
          x_d     = bus.cmd_x0;
          y_d     = bus.cmd_y0;
          x1_d    = bus.cmd_x1;
          y1_d    = bus.cmd_y1;
          color_d = bus.cmd_color;
          pat_d   = bus.cmd_pattern;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          dx_d        = ddx[ERR_W-1] ? -ddx : ddx;
          dy_d        = ddy[ERR_W-1] ? ddy : -ddy;
          err_d       = dx_d + dy_d;
          sx_neg_d    = !(x1_q > x_q);
          sy_neg_d    = !(y1_q > y_q);
          idx_d       = '0;
          pix_valid_d = is_visible(x_q, y_q, pat_q[0]);
          pix_last_d  = pix_valid_d && at_end;
          state_d     = ST_DRAW;
        end
      end

      ST_DRAW: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!advance) begin
          pix_valid_d = pix_valid_q;
          pix_last_d  = pix_last_q;
        end else if (at_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          x_d         = step_x;
          y_d         = step_y;
          err_d       = step_err;
          idx_d       = idx_nxt;
          pix_valid_d = is_visible(step_x, step_y, pat_q[idx_nxt]);
          pix_last_d  = pix_valid_d && (step_x == x1_q) && (step_y == y1_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_color = color_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: directed lines, stalls, clipping, dashes, abort and reset.
module tb_line_rasterizer;

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 16;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          last;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_rasterizer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW), .PAT_WIDTH(PW)) bus ();

  line_rasterizer #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW), .PAT_WIDTH(PW), .H_RES(640), .V_RES(400)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pix_t    sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      hs_cnt   = 0;
  int      done_cnt = 0;
  int      accept_edge, first_valid_edge, last_hs_edge, done_edge;
  bit      first_seen = 1'b0;
  bit      toggle_en  = 1'b0;
  bit      held       = 1'b0;
  pix_t    hv;
  logic [CW-1:0] cur_color;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit last);
    pix_t e;
    e.x = XW'(x);
    e.y = YW'(y);
    e.c = cur_color;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input logic [PW-1:0] pat);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_x0      = XW'(x0);
    bus.cmd_y0      = YW'(y0);
    bus.cmd_x1      = XW'(x1);
    bus.cmd_y1      = YW'(y1);
    bus.cmd_color   = cur_color;
    bus.cmd_pattern = pat;
    bus.cmd_valid   = 1'b1;
    first_seen      = 1'b0;
    accept_edge     = cyc + 1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge clk);
    check({name, "_done_count"}, done_cnt, target);
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  // Pixel/done monitor: pops the scoreboard on every handshake and guards stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !bus.abort) begin
        if (held) begin
          check("stall_valid_held", bus.pix_valid, 1);
          check("stall_data_held", {bus.pix_x, bus.pix_y, bus.pix_color, bus.pix_last},
                {hv.x, hv.y, hv.c, hv.last});
        end
        held = 1'b0;
        if (bus.pix_valid && !first_seen) begin
          first_seen = 1'b1;
          first_valid_edge = cyc + 1;
        end
        if (bus.pix_valid && bus.pix_ready) begin
          hs_cnt++;
          last_hs_edge = cyc + 1;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no pixel", bus.pix_x, bus.pix_y);
          end else begin
            pix_t e;
            e = sb.pop_front();
            check("pix_x", bus.pix_x, e.x);
            check("pix_y", bus.pix_y, e.y);
            check("pix_color", bus.pix_color, e.c);
            check("pix_last", bus.pix_last, e.last);
          end
        end else if (bus.pix_valid) begin
          held = 1'b1;
          hv.x = bus.pix_x;
          hv.y = bus.pix_y;
          hv.c = bus.pix_color;
          hv.last = bus.pix_last;
        end
      end else begin
        held = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        done_edge = cyc + 1;
      end
    end
  end

  // Consumer ready: constant high or toggling every cycle.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) bus.pix_ready = ~bus.pix_ready;
      else bus.pix_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int px[6] = '{3, 3, 2, 2, 1, 1};
    int py[6] = '{5, 4, 3, 2, 1, 0};
    int base;
    int k;

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_x1 = '0; bus.cmd_y0 = '0; bus.cmd_y1 = '0;
    bus.cmd_color = '0; bus.cmd_pattern = '0;
    bus.abort = 1'b0;
    cur_color = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_flags", {bus.pix_last, bus.busy, bus.done}, 3'b000);
    check("rst_pix_data", {bus.pix_x, bus.pix_y, bus.pix_color}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Horizontal line, latency and done timing
    cur_color = 8'h3C;
    for (int i = 0; i < 5; i++) push(i, 0, i == 4);
    issue(0, 0, 4, 0, 16'hFFFF);
    wait_done(1, "hline");
    check("first_pixel_latency", first_valid_edge - accept_edge, 2);
    check("done_after_last", done_edge - last_hs_edge, 1);

    // Steep line going up-left
    cur_color = 8'hA5;
    for (int i = 0; i < 6; i++) push(px[i], py[i], i == 5);
    issue(3, 5, 1, 0, 16'hFFFF);
    wait_done(2, "steep");

    // Same line with a stalling consumer
    cur_color = 8'h5A;
    toggle_en = 1'b1;
    for (int i = 0; i < 6; i++) push(px[i], py[i], i == 5);
    issue(3, 5, 1, 0, 16'hFFFF);
    wait_done(3, "steep_stall");
    toggle_en = 1'b0;

    // Right-edge clipping: end point off screen, so no pix_last
    cur_color = 8'h11;
    for (int i = 637; i < 640; i++) push(i, 0, 1'b0);
    issue(637, 0, 642, 0, 16'hFFFF);
    wait_done(4, "clip");

    // Dash pattern
    cur_color = 8'h77;
    push(0, 0, 1'b0); push(2, 0, 1'b0); push(4, 0, 1'b1);
    issue(0, 0, 4, 0, 16'h5555);
    wait_done(5, "dash");

    // Abort after the 2nd pixel of a diagonal
    cur_color = 8'hC3;
    push(0, 0, 1'b0); push(1, 1, 1'b0);
    base = hs_cnt;
    issue(0, 0, 9, 9, 16'hFFFF);
    k = 0;
    while (hs_cnt < base + 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("abort_two_pixels_seen", hs_cnt - base, 2);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_pix_valid", bus.pix_valid, 0);
    check("abort_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 5);
    check("abort_drained", sb.size(), 0);
    cur_color = 8'h99;
    push(1, 1, 1'b1);
    issue(1, 1, 1, 1, 16'hFFFF);
    wait_done(6, "post_abort_dot");

    // Reset after the 2nd pixel of a diagonal
    cur_color = 8'h2E;
    push(0, 0, 1'b0); push(1, 1, 1'b0);
    base = hs_cnt;
    issue(0, 0, 9, 9, 16'hFFFF);
    k = 0;
    while (hs_cnt < base + 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("reset_two_pixels_seen", hs_cnt - base, 2);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_pix_valid", bus.pix_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_pix_x", bus.pix_x, 0);
    repeat (5) @(negedge clk);
    check("reset_no_done", done_cnt, 6);
    check("reset_drained", sb.size(), 0);
    cur_color = 8'h44;
    push(1, 1, 1'b1);
    issue(1, 1, 1, 1, 16'hFFFF);
    wait_done(7, "post_reset_dot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
